// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow, asynchronous
// clock (or divided clock) in units of clk_in cycles. sig_in passes through a
// 3-flop synchroniser. Rising edges of the synchronised signal start and end
// each measurement. Every completed period produces a one-cycle valid strobe.
// If no edge arrives for MAX_PERIOD cycles, the block raises a sticky timeout
// and drops back to idle.
`timescale 1ns/1ps

module clk_period_meter #(
    parameter int CNT_W      = 16,
    parameter int MAX_PERIOD = 50000   // legal range 2 .. 2**CNT_W-1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             active
);

    localparam int SYNC_STAGES = 3;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Synchroniser chain: r_sync[0] = s1, r_sync[1] = s2, r_sync[2] = s3.
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_d;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_valid;
    logic             r_timeout;

    logic             w_s2;
    logic             w_s3;
    logic             w_rise;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_at_limit;
    logic [CNT_W-1:0] w_s2_ext;

    // Each stage samples the one before it; stage 0 samples the raw input.
    assign w_sync_d = {r_sync[SYNC_STAGES-2:0], sig_in};

    assign w_s2       = r_sync[1];
    assign w_s3       = r_sync[2];
    assign w_rise     = w_s2 & ~w_s3;
    assign w_cnt_inc  = r_cnt + ONE;
    // cnt+1 reaching MAX_PERIOD means a full timeout window has passed since the last edge.
    assign w_at_limit = (w_cnt_inc == MAX_CNT);
    assign w_s2_ext   = {{(CNT_W-1){1'b0}}, w_s2};

    // Shift the asynchronous input through the synchroniser flops.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= w_sync_d;
        end
    end

    // Measurement FSM, counters and result registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            // valid is a single-cycle strobe; only a completed period raises it.
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The first edge only arms the meter. A pending timeout stays set
                    // until a real measurement completes.
                    if (w_rise) begin
                        r_state <= ST_MEASURE;
                        r_cnt   <= '0;
                        r_hcnt  <= ONE;
                    end
                end
                default: begin
                    if (w_rise) begin
                        // An edge that coincides with the limit still counts as a
                        // valid period equal to MAX_PERIOD.
                        r_period    <= w_cnt_inc;
                        r_high_time <= r_hcnt;
                        r_valid     <= 1'b1;
                        r_timeout   <= 1'b0;
                        r_cnt       <= '0;
                        // The edge cycle itself already sees s2 high.
                        r_hcnt      <= ONE;
                    end else if (w_at_limit) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_hcnt    <= '0;
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_hcnt <= r_hcnt + w_s2_ext;
                    end
                end
            endcase
        end
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign timeout   = r_timeout;
    assign active    = (r_state == ST_MEASURE);

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receive-side counterpart to the team's clock dividers: measures an externally supplied slow clock or divided clock against the system clock `clk_in`.
- Synchronises the slow signal, detects its rising edges, and reports period and high time in `clk_in` cycles, with a one-cycle valid strobe per measurement.
- Flags a stopped input clock through a timeout.
- Used to check divider outputs on the bench and in-system.

Parameters:
- CNT_W, 16: width of period/high-time counters and outputs.
- MAX_PERIOD, 50000: timeout limit in `clk_in` cycles; legal range 2..2^CNT_W-1.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sig_in  input  1  measured slow clock; asynchronous to `clk_in`.
- period  output  CNT_W  last measured period, rising edge to rising edge, in `clk_in` cycles.
- high_time  output  CNT_W  cycles `sig_in` (synchronised) was high within that period.
- valid  output  1  one-cycle strobe; `period`/`high_time` updated this cycle.
- timeout  output  1  level; no rising edge for MAX_PERIOD cycles.
- active  output  1  high while state = MEASURE.

Behaviour:
- Reset: asynchronous, active-high; clears all registers immediately.
  - Outputs: period=0, high_time=0, valid=0, timeout=0, active=0.
  - Sync stages s1, s2, s3 = 0; cnt=0; hcnt=0; state=IDLE.
- Synchroniser: s1 <= sig_in, s2 <= s1, s3 <= s2. rise = s2 & ~s3 (combinational).
- Latency: `sig_in` rising before `clk_in` edge k gives s1=1 at edge k, rise=1 during cycle k+1..k+2, and valid=1 after edge k+2.
- Input constraint: `sig_in` high and low phases must each be ≥2 `clk_in` cycles for guaranteed capture. Shorter pulses may be missed; there is no error flag for this.
- State IDLE:
  - counters hold; valid=0.
  - on rise: go to MEASURE, cnt <= 0, hcnt <= 1. No valid (arming edge only).
- State MEASURE, each cycle:
  - If rise:
    - period <= cnt+1; high_time <= hcnt; valid <= 1; timeout <= 0.
    - cnt <= 0; hcnt <= 1; stay in MEASURE.
  - Else if cnt+1 == MAX_PERIOD:
    - timeout <= 1; state <= IDLE; cnt <= 0; hcnt <= 0.
    - period and high_time hold their last values.
  - Else:
    - cnt <= cnt+1; hcnt <= hcnt + s2.
- Rise and timeout in the same cycle: rise wins; period=MAX_PERIOD, valid=1, no timeout.
- valid is deasserted on every cycle not listed above (strictly a one-cycle pulse).
- timeout is sticky until the next valid measurement; it is not cleared by the arming edge.
- active = (state == MEASURE), registered.
- Widths: cnt never exceeds MAX_PERIOD-1, so there is no wrap. hcnt ≤ cnt+1 always; no saturation logic needed.
- Reset mid-measurement: the partial measurement is discarded. The first rise after reset only arms.

Test Plan:
- Reset values: assert reset asynchronously mid-cycle → all outputs 0 immediately, before the next `clk_in` edge. Release; hold `sig_in`=0 for 100 cycles → valid never asserts, active=0.
- 50% duty: `sig_in` toggles every 5 `clk_in` cycles (divide-by-10) →
  - first rise only arms (active=1, no valid);
  - each later rise gives valid exactly once with period=10, high_time=5;
  - strobes are 10 cycles apart;
  - first valid arrives 3 edges after the second `sig_in` rise.
- Asymmetric duty: `sig_in` high 3 cycles, low 7 cycles → period=10, high_time=3 on every strobe. Then switch to high 12, low 4 → first strobe after the change reports period=16, high_time=12.
- Timeout (MAX_PERIOD=64): arm, take one valid measurement, then hold `sig_in` low →
  - timeout=1 and active=0 exactly 64 cycles after the last rise detection;
  - period/high_time keep their last values.
  - Restart `sig_in` at period 10 → next rise arms (timeout still 1), following rise gives valid with period=10 and timeout=0.
- Boundary (MAX_PERIOD=64): `sig_in` period exactly 64 cycles → valid with period=64 every strobe, timeout never asserts. Period 65 → timeout asserts, never valid.
- Reset mid-measurement: assert reset 4 cycles after a rise, release, continue `sig_in` at period 10 → first post-reset rise gives no valid; second gives period=10.
